// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit two-register CPU: sequences
// FETCH/DECODE/EXEC/MEM/WB and strobes the PC, IR, ALU, register file and memories.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             rt,
  input  logic             rs,
  input  logic [2:0]       aux,
  input  logic             rs_zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             wb_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  // Handshake: a request stays high from the cycle its state is entered until
  // the cycle the matching ack is seen; acks while the request is low are ignored.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_ERR  = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0]    TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_src_imm_q, alu_src_imm_d, rf_we_q, rf_we_d;
  logic             rf_wsel_q, rf_wsel_d, wb_src_q, wb_src_d, halted_q, halted_d;
  logic             err_q, err_d, branch_taken;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        tmo_d   = '0;
      end
      S_FETCH: begin
        if (imem_ack)               state_d = S_DECODE;
        else if (tmo_q == TMO_LAST) state_d = S_ERR;
        else                        tmo_d   = tmo_q + 1'b1;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        tmo_d = '0;
        if (opcode == OP_LD || opcode == OP_ST) begin
          state_d = S_MEM;
        end else if (opcode == OP_BEQZ) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (opcode == OP_ST) begin
            state_d = S_FETCH;
            retire  = 1'b1;
            tmo_d   = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        tmo_d   = '0;
      end
      default: state_d = state_q;
    endcase

    cnt_d = (retire && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    // Outputs are registered from the next state so they line up with state_q.
    imem_req_d    = (state_d == S_FETCH);
    dmem_req_d    = (state_d == S_MEM);
    dmem_we_d     = (state_d == S_MEM) && (opcode == OP_ST);
    alu_op_d      = 2'b00;
    alu_src_imm_d = 1'b0;
    if (state_d == S_EXEC) begin
      case (opcode)
        OP_SUB:                alu_op_d = 2'b01;
        OP_AND:                alu_op_d = 2'b10;
        default:               alu_op_d = 2'b00;
      endcase
      alu_src_imm_d = (opcode == OP_ADDI) || (opcode == OP_LD) || (opcode == OP_ST);
    end
    rf_we_d   = (state_d == S_WB);
    rf_wsel_d = (state_d == S_WB) ? rt : 1'b0;
    wb_src_d  = (state_d == S_WB) && (opcode == OP_LD);
    halted_d  = (state_d == S_HALT);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      cnt_q         <= '0;
      imem_req_q    <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      alu_op_q      <= 2'b00;
      alu_src_imm_q <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_wsel_q     <= 1'b0;
      wb_src_q      <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      cnt_q         <= cnt_d;
      imem_req_q    <= imem_req_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      alu_op_q      <= alu_op_d;
      alu_src_imm_q <= alu_src_imm_d;
      rf_we_q       <= rf_we_d;
      rf_wsel_q     <= rf_wsel_d;
      wb_src_q      <= wb_src_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
    end
  end

  // Ack- and flag-driven PC/IR strobes must land in the same cycle they are seen.
  assign branch_taken = (state_q == S_EXEC) && (opcode == OP_BEQZ) && rs_zero;
  assign ir_we        = (state_q == S_FETCH) && imem_ack;
  assign pc_we        = ir_we || branch_taken;
  assign pc_src       = branch_taken;

  assign imem_req    = imem_req_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign alu_op      = alu_op_q;
  assign alu_src_imm = alu_src_imm_q;
  assign rf_we       = rf_we_q;
  assign rf_wsel     = rf_wsel_q;
  assign wb_src      = wb_src_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random programs against a transaction-level model,
// plus a short-timeout, narrow-counter instance for timeout and saturation.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 0, rt = 0, rs = 0, rs_zero = 0, imem_ack = 0, dmem_ack = 0;
  logic [2:0] opcode = 0, aux = 0;

  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_imm, rf_we, rf_wsel, wb_src;
  logic halted, err;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic imem_req_b, dmem_req_b, dmem_we_b, ir_we_b, pc_we_b, pc_src_b, alu_src_imm_b;
  logic rf_we_b, rf_wsel_b, wb_src_b, halted_b, err_b;
  logic [1:0] alu_op_b, instr_count_b;
  logic [2:0] state_b;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .rt(rt), .rs(rs), .aux(aux),
    .rs_zero(rs_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .wb_src(wb_src), .state(state), .halted(halted), .err(err), .instr_count(instr_count)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .rt(rt), .rs(rs), .aux(aux),
    .rs_zero(rs_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req_b),
    .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .ir_we(ir_we_b), .pc_we(pc_we_b),
    .pc_src(pc_src_b), .alu_op(alu_op_b), .alu_src_imm(alu_src_imm_b), .rf_we(rf_we_b),
    .rf_wsel(rf_wsel_b), .wb_src(wb_src_b), .state(state_b), .halted(halted_b), .err(err_b),
    .instr_count(instr_count_b)
  );

  int tests = 0;
  int fails = 0;
  int model_count = 0;
  bit mon_en = 0;

  logic [1:0] exp_pc_q[$];    // {pc_src, ir_we} per pc_we pulse
  logic [2:0] exp_exec_q[$];  // {alu_op, alu_src_imm} per EXEC cycle
  logic [1:0] exp_wb_q[$];    // {rf_wsel, wb_src} per rf_we pulse
  logic [0:0] exp_mem_q[$];   // dmem_we at each data ack
  logic [7:0] exp_lat_q[$];   // cycles from one fetch start to the next

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic empty_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event, nothing expected at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_imem();
    int b = 0;
    while (!imem_req && b < 40) begin tick(); b++; end
    chk("imem_req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_dmem();
    int b = 0;
    while (!dmem_req && b < 20) begin tick(); b++; end
    chk("dmem_req_seen", {31'd0, dmem_req}, 32'd1);
  endtask

  // Reference model: what one instruction must produce, from the ISA rules.
  task automatic issue(input logic [2:0] op, input logic t, input logic s, input logic [2:0] a,
                       input logic rz, input int di, input int dd);
    int lat;
    exp_pc_q.push_back(2'b01);
    if (op == 3'd6 && rz) exp_pc_q.push_back(2'b10);
    if (op != 3'd6) exp_exec_q.push_back((op < 3'd3) ? {op[1:0], 1'b0} : 3'b001);
    if (op <= 3'd3) exp_wb_q.push_back({t, 1'b0});
    if (op == 3'd4) exp_wb_q.push_back({t, 1'b1});
    if (op == 3'd4) exp_mem_q.push_back(1'b0);
    if (op == 3'd5) exp_mem_q.push_back(1'b1);
    case (op)
      3'd4:    lat = 5 + di + dd;
      3'd5:    lat = 4 + di + dd;
      3'd6:    lat = 3 + di;
      default: lat = 4 + di;
    endcase
    exp_lat_q.push_back(8'(lat));
    model_count++;
    wait_imem();
    repeat (di) tick();
    imem_ack = 1; opcode = op; rt = t; rs = s; aux = a; rs_zero = rz;
    tick();
    imem_ack = 0;
    if (op == 3'd4 || op == 3'd5) begin
      wait_dmem();
      repeat (dd) tick();
      dmem_ack = 1;
      tick();
      dmem_ack = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  // Monitor: pops and compares whenever the DUT shows an observable event.
  logic mon_prev = 0;
  bit   mon_started = 0;
  int   mon_cnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (pc_we) begin
        if (exp_pc_q.size() == 0) empty_fail("pc_we");
        else chk("pc_event", {30'd0, pc_src, ir_we}, {30'd0, exp_pc_q.pop_front()});
      end
      if (state == 3'd3 && opcode != 3'd6) begin
        if (exp_exec_q.size() == 0) empty_fail("exec");
        else chk("exec_alu", {29'd0, alu_op, alu_src_imm}, {29'd0, exp_exec_q.pop_front()});
      end
      if (rf_we) begin
        if (exp_wb_q.size() == 0) empty_fail("rf_we");
        else chk("wb_event", {30'd0, rf_wsel, wb_src}, {30'd0, exp_wb_q.pop_front()});
      end
      if (dmem_req && dmem_ack) begin
        if (exp_mem_q.size() == 0) empty_fail("dmem");
        else chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_mem_q.pop_front()});
      end
      if (imem_req && !mon_prev) begin
        if (mon_started) begin
          if (exp_lat_q.size() == 0) empty_fail("latency");
          else chk("latency", mon_cnt, {24'd0, exp_lat_q.pop_front()});
        end
        mon_cnt = 1;
        mon_started = 1;
      end else begin
        mon_cnt++;
      end
      mon_prev = imem_req;
    end else begin
      mon_prev = 0;
      mon_started = 0;
      mon_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #12;
    chk("reset_outs", {17'd0, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op,
        alu_src_imm, rf_we, rf_wsel, wb_src, state, halted, err}, 32'd0);
    chk("reset_cnt", {16'd0, instr_count}, 32'd0);
    chk("reset_cnt_b", {30'd0, instr_count_b}, 32'd0);
    rst_n = 1;
    tick();
    chk("idle_state", {29'd0, state}, 32'd0);

    // ADD with imem ack one cycle after request: state walk 1,2,3,5,1
    mon_en = 1;
    start = 1;
    tick();
    start = 0;
    chk("t1_fetch", {29'd0, state}, 32'd1);
    issue(3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1, 0);
    chk("t1_decode", {29'd0, state}, 32'd2);
    tick();
    chk("t1_exec", {29'd0, state}, 32'd3);
    tick();
    chk("t1_wb", {29'd0, state}, 32'd5);
    tick();
    chk("t1_refetch", {29'd0, state}, 32'd1);
    chk("t1_count", {16'd0, instr_count}, 32'd1);

    // LD with a 3-cycle data wait, then BEQZ taken and not taken
    issue(3'd4, 1'b0, 1'b1, 3'd3, 1'b0, 0, 3);
    issue(3'd6, 1'b0, 1'b0, 3'd2, 1'b1, 0, 0);
    issue(3'd6, 1'b0, 1'b1, 3'd5, 1'b0, 2, 0);

    // Random program; waits stay within the short-timeout instance's limit
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // HALT retires and is terminal
    exp_pc_q.push_back(2'b01);
    wait_imem();
    imem_ack = 1; opcode = 3'd7;
    tick();
    imem_ack = 0;
    tick();
    chk("halt_state", {29'd0, state}, 32'd6);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_count", {16'd0, instr_count}, model_count + 1);
    chk("sat_count_b", {30'd0, instr_count_b}, 32'd3);
    chk("halt_b_no_err", {30'd0, halted_b, err_b}, 32'd2);
    start = 1; imem_ack = 1;
    tick();
    tick();
    start = 0; imem_ack = 0;
    tick();
    chk("halt_sticky", {29'd0, state}, 32'd6);
    chk("halt_count_hold", {16'd0, instr_count}, model_count + 1);
    chk("halt_no_req", {31'd0, imem_req}, 32'd0);
    mon_en = 0;
    chk("queues_drained", exp_pc_q.size() + exp_exec_q.size() + exp_wb_q.size()
        + exp_mem_q.size() + exp_lat_q.size(), 32'd0);

    // Ack on the last allowed cycle wins over the timeout
    do_reset();
    start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    imem_ack = 1; opcode = 3'd0;
    tick();
    imem_ack = 0;
    chk("tmo_edge_state_b", {29'd0, state_b}, 32'd2);
    chk("tmo_edge_err_b", {31'd0, err_b}, 32'd0);

    // Withheld imem ack: ERR after exactly MEM_TIMEOUT request cycles
    do_reset();
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (state_b != 3'd7 && n < 20) begin
      if (imem_req_b) n++;
      tick();
    end
    chk("tmo_req_cycles", n, 32'd4);
    chk("err_flag", {31'd0, err_b}, 32'd1);
    chk("err_req_low", {31'd0, imem_req_b}, 32'd0);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("err_sticky", {29'd0, state_b}, 32'd7);

    // Reset during MEM drops dmem_req asynchronously and clears the counter
    do_reset();
    start = 1;
    tick();
    start = 0;
    issue(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 0, 0);
    wait_imem();
    chk("pre_reset_count", {16'd0, instr_count}, 32'd1);
    imem_ack = 1; opcode = 3'd4;
    tick();
    imem_ack = 0;
    wait_dmem();
    tick();
    #2 rst_n = 0;
    #1;
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    exp_pc_q.delete(); exp_exec_q.delete(); exp_wb_q.delete();
    exp_mem_q.delete(); exp_lat_q.delete();
    tick();
    rst_n = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
